// File: rtl/uart_pkg.sv
// Shared constants and types for the UART command link (encoder and decoder).
package uart_pkg;

  localparam logic [1:0] ENC_DATA_T  = 2'b00;
  localparam logic [1:0] ENC_ACK_T   = 2'b01;
  localparam logic [1:0] ENC_ERR_T   = 2'b10;
  localparam logic [1:0] ENC_SPACE_T = 2'b11;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_W  = 8'h57;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;

  // Number of nibble values below 'A' in the hex alphabet.
  localparam int unsigned HEX_ALPHA_BASE = 10;

  typedef enum logic [2:0] {
    ENC_IDLE  = 3'd0,
    ENC_CHAR  = 3'd1,
    ENC_DIGIT = 3'd2,
    ENC_CR    = 3'd3,
    ENC_LF    = 3'd4,
    ENC_FIN   = 3'd5
  } enc_state_t;

endpackage

// File: rtl/hex2ascii.sv
// Combinational nibble to uppercase ASCII hex character converter.
module hex2ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii_c
);

  always_comb begin
    if (32'(nibble) < HEX_ALPHA_BASE) begin
      ascii_c = ASCII_0 + 8'(nibble);
    end else begin
      ascii_c = ASCII_A + 8'(nibble) - 8'(HEX_ALPHA_BASE);
    end
  end

endmodule

// File: rtl/uart_hex_enc.sv
// ASCII response encoder: serialises DATA/ACK/ERROR/SPACE responses into bytes
// handed to the UART transmitter over a registered valid/ready handshake.
module uart_hex_enc
  import uart_pkg::*;
#(
  parameter  int unsigned N_DIGITS = 4,
  localparam int unsigned DW       = 4 * N_DIGITS
) (
  input  logic          CLK_100M,
  input  logic          SYS_RST,
  input  logic          ENC_START,
  input  logic [1:0]    ENC_TYPE,
  input  logic [DW-1:0] ENC_DATA,
  output logic          ENC_BUSY,
  output logic          ENC_DONE,
  output logic          UART_TX_DVLD,
  output logic [7:0]    UART_TX_DATA,
  input  logic          UART_TX_READY
);

  localparam int unsigned CW          = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam bit          MULTI_DIGIT = (N_DIGITS > 1);
  localparam logic [CW-1:0] CNT_LOAD  =
    CW'((N_DIGITS > 1) ? (N_DIGITS - 32'd2) : 32'd0);

  enc_state_t    state,   state_nxt;
  logic          busy,    busy_nxt;
  logic          done,    done_nxt;
  logic          dvld,    dvld_nxt;
  logic [7:0]    tx_data, tx_data_nxt;
  logic [CW-1:0] cnt,     cnt_nxt;
  logic [DW-1:0] shift,   shift_nxt;
  logic [1:0]    typ,     typ_nxt;

  logic          xfer_c;
  logic [3:0]    nib_c;
  logic [7:0]    hex_c;

  assign xfer_c = dvld & UART_TX_READY;

  // At accept the first digit comes straight from the input word; afterwards
  // the pre-shifted register supplies the next digit in its top nibble.
  assign nib_c = (state == ENC_IDLE) ? ENC_DATA[DW-1 -: 4] : shift[DW-1 -: 4];

  hex2ascii u_hex2ascii (
    .nibble  (nib_c),
    .ascii_c (hex_c)
  );

  always_comb begin
    state_nxt   = state;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    dvld_nxt    = dvld;
    tx_data_nxt = tx_data;
    cnt_nxt     = cnt;
    shift_nxt   = shift;
    typ_nxt     = typ;

    unique case (state)
      ENC_IDLE: begin
        if (ENC_START) begin
          state_nxt = ENC_CHAR;
          busy_nxt  = 1'b1;
          dvld_nxt  = 1'b1;
          typ_nxt   = ENC_TYPE;
          shift_nxt = DW'({ENC_DATA, 4'h0});
          unique case (ENC_TYPE)
            ENC_DATA_T: tx_data_nxt = hex_c;
            ENC_ACK_T:  tx_data_nxt = ASCII_K;
            ENC_ERR_T:  tx_data_nxt = ASCII_E;
            default:    tx_data_nxt = ASCII_SP;
          endcase
        end
      end

      ENC_CHAR: begin
        if (xfer_c) begin
          if (typ == ENC_SPACE_T) begin
            state_nxt = ENC_FIN;
            dvld_nxt  = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else if ((typ == ENC_DATA_T) && MULTI_DIGIT) begin
            state_nxt   = ENC_DIGIT;
            cnt_nxt     = CNT_LOAD;
            tx_data_nxt = hex_c;
            shift_nxt   = DW'({shift, 4'h0});
          end else begin
            state_nxt   = ENC_CR;
            tx_data_nxt = ASCII_CR;
          end
        end
      end

      ENC_DIGIT: begin
        if (xfer_c) begin
          if (cnt == '0) begin
            state_nxt   = ENC_CR;
            tx_data_nxt = ASCII_CR;
          end else begin
            cnt_nxt     = cnt - CW'(1);
            tx_data_nxt = hex_c;
            shift_nxt   = DW'({shift, 4'h0});
          end
        end
      end

      ENC_CR: begin
        if (xfer_c) begin
          state_nxt   = ENC_LF;
          tx_data_nxt = ASCII_LF;
        end
      end

      ENC_LF: begin
        if (xfer_c) begin
          state_nxt = ENC_FIN;
          dvld_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end
      end

      ENC_FIN: begin
        state_nxt = ENC_IDLE;
      end

      default: begin
        state_nxt = ENC_IDLE;
        busy_nxt  = 1'b0;
        dvld_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_100M) begin
    if (SYS_RST) begin
      state   <= ENC_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      dvld    <= 1'b0;
      tx_data <= 8'h00;
      cnt     <= '0;
      shift   <= '0;
      typ     <= 2'b00;
    end else begin
      state   <= state_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      dvld    <= dvld_nxt;
      tx_data <= tx_data_nxt;
      cnt     <= cnt_nxt;
      shift   <= shift_nxt;
      typ     <= typ_nxt;
    end
  end

  assign ENC_BUSY     = busy;
  assign ENC_DONE     = done;
  assign UART_TX_DVLD = dvld;
  assign UART_TX_DATA = tx_data;

endmodule
